// File: rtl/seq_pkg.sv
// ---------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the sequence-detector family of blocks.
//   state_t     : window FSM encoding (IDLE, COUNT)
//   DEF_CNT_W   : default width of a match count
//   DEF_WIN_W   : default width of a window-length value
// ---------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   localparam int DEF_CNT_W = 8;
   localparam int DEF_WIN_W = 8;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating, clearable event counter used as the match accumulator.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   clr           : restart the count from zero next cycle (wins over inc)
//   inc           : count one event this cycle
//   total         : current count including this cycle's inc, saturated
//   total_sat     : an increment was lost to saturation, including this cycle
// ---------------------------------------------------------------------------
module sat_counter
   import seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] total,
   output logic             total_sat
);

   localparam logic [CNT_W-1:0] MAX_COUNT = '1;

   logic [CNT_W-1:0] count;
   logic             sat;
   logic             at_max;

   // The combinational totals fold in the current cycle's event so the owner
   // can capture a result on the last window cycle without losing that event.
   // Once at the ceiling the count holds and the sat bit records the overflow.
   always_comb begin
      at_max    = (count == MAX_COUNT);
      total     = count;
      total_sat = sat | (inc & at_max);
      if (inc && !at_max) begin
         total = count + CNT_W'(1);
      end
   end

   // Accumulator register; a clear restarts a fresh window, so it takes
   // priority over any event arriving in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else begin
         count <= total;
         sat   <= total_sat;
      end
   end

endmodule

// File: rtl/seq_match_counter.sv
// ---------------------------------------------------------------------------
// seq_match_counter
// Counts detector match pulses over back-to-back windows of win_len cycles
// and presents each window's count through a valid/ready output register.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   det          : match pulse, one event per high cycle
//   en           : counting enable; dropping it abandons the current window
//   win_len      : window length in cycles, sampled at window start (0 -> 1)
//   cnt_ready    : downstream accepts the presented result
//   clr_drop     : clears the sticky drop flag
//   cnt_out      : match count of the last completed window
//   cnt_valid    : cnt_out/sat hold a result not yet accepted
//   sat          : the presented count saturated
//   drop         : sticky, a completed window was lost to back-pressure
// ---------------------------------------------------------------------------
module seq_match_counter
   import seq_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W,
   parameter int WIN_W = DEF_WIN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             det,
   input  logic             en,
   input  logic [WIN_W-1:0] win_len,
   input  logic             cnt_ready,
   input  logic             clr_drop,
   output logic [CNT_W-1:0] cnt_out,
   output logic             cnt_valid,
   output logic             sat,
   output logic             drop
);

   state_t           state;
   state_t           state_next;
   logic [WIN_W-1:0] remaining;
   logic [WIN_W-1:0] win_load;
   logic             load_win;
   logic             last_cycle;
   logic             clr_acc;
   logic             acc_inc;
   logic [CNT_W-1:0] acc_total;
   logic             acc_total_sat;
   logic             drop_set;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr_acc),
      .inc      (acc_inc),
      .total    (acc_total),
      .total_sat(acc_total_sat)
   );

   // Window sequencing. A window is the run of COUNT cycles; the cycle that
   // leaves IDLE only latches the length. On the last window cycle the next
   // window is armed at once, so consecutive windows have no gap. Losing en
   // abandons the partial window and clears the accumulator.
   always_comb begin
      state_next = state;
      load_win   = 1'b0;
      last_cycle = 1'b0;
      clr_acc    = 1'b0;
      acc_inc    = 1'b0;
      win_load   = (win_len == '0) ? WIN_W'(1) : win_len;
      unique case (state)
         IDLE: begin
            clr_acc = 1'b1;
            if (en) begin
               state_next = COUNT;
               load_win   = 1'b1;
            end
         end
         COUNT: begin
            if (!en) begin
               state_next = IDLE;
               clr_acc    = 1'b1;
            end else begin
               acc_inc = det;
               if (remaining == WIN_W'(1)) begin
                  last_cycle = 1'b1;
                  load_win   = 1'b1;
                  clr_acc    = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            clr_acc    = 1'b1;
         end
      endcase
   end

   // State register and the window down-counter, which counts the cycles
   // still left in the current window (1 means this is the last one).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         remaining <= '0;
      end else begin
         state <= state_next;
         if (load_win) begin
            remaining <= win_load;
         end else if (state == COUNT) begin
            remaining <= remaining - WIN_W'(1);
         end
      end
   end

   // Output register. A finished window is loaded if the register is empty
   // or its current content is being accepted this very cycle; otherwise the
   // held result stays untouched and the new one is reported as dropped.
   always_comb begin
      drop_set = last_cycle & cnt_valid & ~cnt_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_out   <= '0;
         sat       <= 1'b0;
         cnt_valid <= 1'b0;
      end else if (last_cycle && (!cnt_valid || cnt_ready)) begin
         cnt_out   <= acc_total;
         sat       <= acc_total_sat;
         cnt_valid <= 1'b1;
      end else if (cnt_valid && cnt_ready) begin
         cnt_valid <= 1'b0;
      end
   end

   // Sticky drop flag; a new drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop <= 1'b0;
      end else if (drop_set) begin
         drop <= 1'b1;
      end else if (clr_drop) begin
         drop <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_match_counter.sv
// ---------------------------------------------------------------------------
// tb_seq_match_counter
// Self-checking bench for seq_match_counter (CNT_W=4 so saturation is cheap
// to reach). Stimulus drives inputs on the falling edge and steps a
// behavioural model that counts events as plain integers; each result the
// model expects is queued, and a monitor pops and compares whenever the DUT
// presents a new result.
// ---------------------------------------------------------------------------
module tb_seq_match_counter;

   localparam int CNT_W = 4;
   localparam int WIN_W = 8;
   localparam int MAXV  = (1 << CNT_W) - 1;

   typedef struct {
      int cnt;
      bit sat;
   } result_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             det;
   logic             en;
   logic [WIN_W-1:0] win_len;
   logic             cnt_ready;
   logic             clr_drop;
   logic [CNT_W-1:0] cnt_out;
   logic             cnt_valid;
   logic             sat;
   logic             drop;

   int n_checks = 0;
   int n_fails  = 0;

   result_t exp_q[$];

   bit m_active = 0;
   int m_len    = 0;
   int m_elapsed = 0;
   int m_true   = 0;
   bit m_valid  = 0;
   bit m_drop   = 0;

   bit               acc_seen   = 0;
   bit               prev_valid = 0;
   logic [CNT_W-1:0] held_cnt   = '0;
   logic             held_sat   = 1'b0;

   seq_match_counter #(
      .CNT_W(CNT_W),
      .WIN_W(WIN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .det      (det),
      .en       (en),
      .win_len  (win_len),
      .cnt_ready(cnt_ready),
      .clr_drop (clr_drop),
      .cnt_out  (cnt_out),
      .cnt_valid(cnt_valid),
      .sat      (sat),
      .drop     (drop)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   // Single comparison point: every check goes through here.
   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model for one rising edge: windows are tracked as elapsed
   // cycles against a length, and the count as an unbounded integer that is
   // only clipped when the result is produced.
   task automatic modelStep(input bit d, input bit e, input int w, input bit r, input bit c);
      bit      done;
      bit      lost;
      result_t res;
      done = 0;
      lost = 0;
      res.cnt = 0;
      res.sat = 0;
      if (!m_active) begin
         if (e) begin
            m_active  = 1;
            m_len     = (w == 0) ? 1 : w;
            m_elapsed = 0;
            m_true    = 0;
         end
      end else if (!e) begin
         m_active = 0;
      end else begin
         m_true    += int'(d);
         m_elapsed += 1;
         if (m_elapsed == m_len) begin
            done      = 1;
            res.cnt   = (m_true > MAXV) ? MAXV : m_true;
            res.sat   = (m_true > MAXV);
            m_len     = (w == 0) ? 1 : w;
            m_elapsed = 0;
            m_true    = 0;
         end
      end
      if (done) begin
         if (!m_valid || r) begin
            exp_q.push_back(res);
            m_valid = 1;
         end else begin
            lost = 1;
         end
      end else if (m_valid && r) begin
         m_valid = 0;
      end
      if (lost) begin
         m_drop = 1;
      end else if (c) begin
         m_drop = 0;
      end
   endtask

   // Per-cycle flag comparison against the model.
   task automatic checkOutput();
      check("cnt_valid", int'(cnt_valid), int'(m_valid));
      check("drop", int'(drop), int'(m_drop));
   endtask

   // One clock of stimulus: verify the previous edge, drive, step the model.
   task automatic applyStimulus(input bit d, input bit e, input int w, input bit r, input bit c);
      @(negedge clk);
      checkOutput();
      det       = d;
      en        = e;
      win_len   = WIN_W'(w);
      cnt_ready = r;
      clr_drop  = c;
      modelStep(d, e, w, r, c);
   endtask

   // Short reset pulse placed between clock edges.
   task automatic applyReset();
      @(negedge clk);
      checkOutput();
      #2;
      rst_n    = 1'b0;
      det      = 1'b0;
      en       = 1'b0;
      clr_drop = 1'b0;
      #1;
      check("rst_cnt_out", int'(cnt_out), 0);
      check("rst_cnt_valid", int'(cnt_valid), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_drop", int'(drop), 0);
      #1;
      rst_n    = 1'b1;
      m_active = 0;
      m_valid  = 0;
      m_drop   = 0;
      modelStep(1'b0, 1'b0, int'(win_len), cnt_ready, 1'b0);
   endtask

   // Records whether the presented result was taken at each rising edge.
   always @(posedge clk) begin
      acc_seen <= cnt_valid & cnt_ready;
   end

   // Monitor: a result is new when valid rises or stays up after an accept;
   // otherwise a held result must not move.
   always @(negedge clk) begin
      if (rst_n) begin
         if (cnt_valid && (!prev_valid || acc_seen)) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("[TB] FAIL unexpected_result: got cnt %0d sat %0d, expected none at %0t",
                        cnt_out, sat, $time);
            end else begin
               result_t e;
               e = exp_q.pop_front();
               check("result_cnt", int'(cnt_out), e.cnt);
               check("result_sat", int'(sat), int'(e.sat));
            end
            held_cnt = cnt_out;
            held_sat = sat;
         end else if (cnt_valid && prev_valid) begin
            check("hold_cnt", int'(cnt_out), int'(held_cnt));
            check("hold_sat", int'(sat), int'(held_sat));
         end
      end
      prev_valid = cnt_valid;
   end

   initial begin
      rst_n     = 1'b0;
      det       = 1'b0;
      en        = 1'b0;
      win_len   = '0;
      cnt_ready = 1'b0;
      clr_drop  = 1'b0;
      repeat (2) @(negedge clk);
      check("init_cnt_out", int'(cnt_out), 0);
      check("init_cnt_valid", int'(cnt_valid), 0);
      check("init_sat", int'(sat), 0);
      check("init_drop", int'(drop), 0);
      rst_n = 1'b1;
      modelStep(1'b0, 1'b0, 0, 1'b0, 1'b0);

      $display("[TB] window of 8, events on cycles 1, 4, 8");
      applyStimulus(0, 1, 8, 1, 0);
      for (int i = 1; i <= 8; i++) begin
         applyStimulus((i == 1 || i == 4 || i == 8), 1, 8, 1, 0);
      end
      applyStimulus(0, 0, 8, 1, 0);
      check("win8_cnt", int'(cnt_out), 3);
      applyStimulus(0, 0, 8, 1, 0);

      $display("[TB] window of 20, event every cycle");
      applyStimulus(1, 1, 20, 1, 0);
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 1, 20, 1, 0);
      end
      applyStimulus(0, 0, 20, 1, 0);
      check("sat_cnt", int'(cnt_out), MAXV);
      check("sat_flag", int'(sat), 1);
      applyStimulus(0, 0, 20, 1, 0);

      $display("[TB] back-pressure over several windows of 4");
      applyStimulus(0, 1, 4, 0, 0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus((i < 4), 1, 4, 0, 0);
      end
      applyStimulus(0, 0, 4, 0, 0);
      check("held_cnt", int'(cnt_out), 4);
      check("held_drop", int'(drop), 1);
      applyStimulus(0, 0, 4, 0, 1);
      applyStimulus(0, 0, 4, 1, 0);
      applyStimulus(0, 0, 4, 1, 0);

      $display("[TB] one-cycle windows with accept on every completion");
      applyStimulus(0, 1, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i[0], 1, 0, 1, 0);
      end
      applyStimulus(0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1, 0);

      $display("[TB] enable dropped mid-window");
      applyStimulus(0, 1, 6, 1, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 6, 1, 0);
      end
      applyStimulus(1, 0, 6, 1, 0);
      applyStimulus(1, 1, 6, 1, 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i[0], 1, 6, 1, 0);
      end
      applyStimulus(0, 0, 6, 1, 0);
      check("reen_cnt", int'(cnt_out), 3);
      applyStimulus(0, 0, 6, 1, 0);

      $display("[TB] reset pulse mid-window");
      applyStimulus(0, 1, 10, 1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 10, 0, 0);
      end
      applyReset();
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1, 0, 10, 1, 0);
      end

      $display("[TB] randomized traffic");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus(bit'($urandom_range(0, 1)),
                       ($urandom_range(0, 19) != 0),
                       int'($urandom_range(0, 20)),
                       bit'($urandom_range(0, 1)),
                       ($urandom_range(0, 15) == 0));
      end

      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 1, 0);
      end
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/seq_match_counter.md
SEQ_MATCH_COUNTER -- requirements
Module: seq_match_counter

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 8, as the width of the match count.
REQ-002 The block SHALL provide parameter WIN_W, default 8, as the width of the window-length input.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port det, input, 1 bit: match pulse from the upstream Moore sequence detector, one event per high cycle.
REQ-006 The block SHALL have port en, input, 1 bit: counting enable.
REQ-007 The block SHALL have port win_len, input, WIN_W bits: window length in clk cycles, sampled at window start.
REQ-008 The block SHALL have port cnt_ready, input, 1 bit: downstream accepts the result.
REQ-009 The block SHALL have port clr_drop, input, 1 bit: clears the sticky drop flag.
REQ-010 The block SHALL have port cnt_out, output, CNT_W bits: match count of the completed window.
REQ-011 The block SHALL have port cnt_valid, output, 1 bit: cnt_out holds a valid result.
REQ-012 The block SHALL have port sat, output, 1 bit: the presented result saturated.
REQ-013 The block SHALL have port drop, output, 1 bit: sticky flag, set when a window result was lost.

Function
REQ-014 The FSM SHALL have states IDLE and COUNT; the output register SHALL be tracked independently by cnt_valid.
REQ-015 IDLE -> COUNT SHALL occur on the first cycle with en=1; win_len SHALL be latched then, with value 0 treated as 1.
REQ-016 In COUNT, each cycle with det=1, including the first and last window cycles, SHALL increment the accumulator.
REQ-017 The accumulator SHALL saturate at 2^CNT_W-1, with no wrap-around, and SHALL set an internal sat bit.
REQ-018 After exactly the latched window length of cycles, the accumulator plus that cycle's det SHALL be transferred to cnt_out/sat.
REQ-019 cnt_valid SHALL assert in the cycle after the last window cycle (latency 1).
REQ-020 The next window SHALL start immediately at that transfer, without an idle gap, if en=1.
REQ-021 Handshake: the result is accepted on a cycle with cnt_valid=1 and cnt_ready=1; cnt_valid SHALL deassert next cycle unless a new result is transferred in the same cycle.
REQ-022 While cnt_valid=1 and cnt_ready=0, cnt_out and sat SHALL remain stable.
REQ-023 If a window completes while cnt_valid=1 and cnt_ready=0, the new result SHALL be discarded, the held result SHALL be kept, and drop SHALL be set.
REQ-024 If a window completes in the same cycle that the held result is accepted, the new result SHALL be loaded and cnt_valid SHALL stay 1, with no drop.
REQ-025 en=0 during COUNT SHALL return the FSM to IDLE and discard the partial count; a pending result SHALL remain presented.
REQ-026 clr_drop=1 SHALL clear drop next cycle; if it coincides with a drop event, set SHALL win.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, accumulator=0, cnt_out=0, cnt_valid=0, sat=0, and drop=0, independent of clk.
REQ-028 Reset deassertion SHALL take effect at the next clk edge; a reset applied mid-window SHALL lose that window with no drop flagged.

Structure
REQ-029 The FSM state encoding (IDLE, COUNT) and the default CNT_W/WIN_W values SHALL live in a shared package seq_pkg used by the detector blocks.
REQ-030 A single sub-module, sat_counter (a saturating, clearable counter of CNT_W bits), SHALL implement the accumulator; the window down-counter SHALL be inline.

Verification
REQ-031 Scenario: win_len=8, det high on cycles 1,4,8, cnt_ready=1 -> cnt_out=3 with cnt_valid for one cycle, asserted one cycle after window end.
REQ-032 Scenario: CNT_W=4, win_len=20, det high 20 cycles -> cnt_out=15, sat=1.
REQ-033 Scenario: win_len=4, cnt_ready=0 for two windows -> first result held stable, drop=1; clr_drop -> drop=0.
REQ-034 Scenario: acceptance in the same cycle as the next window completes -> cnt_valid stays 1, new count shown, drop=0.
REQ-035 Scenario: en dropped mid-window, then re-raised -> partial count discarded, next window counts from 0; win_len=0 -> 1-cycle windows.
REQ-036 Scenario: rst_n pulsed low between clk edges mid-window -> all outputs 0 immediately, no result produced.
